// File: rtl/pkt_router.sv
// rtl/pkt_router.sv - parametrised byte-stream packet router with per-channel backpressure
//
// Purpose:
//    Parses PREFIX / addr / dest / len headers from a valid/ready byte stream
//    and forwards len payload bytes to channel dest. Packets for another
//    address or an out-of-range channel are consumed and dropped. A packet
//    that goes idle for TIMEOUT_CYC cycles is aborted.
//
// Optional feature macro: PKT_ROUTER_CHECKSUM_EN
//    Adds a trailing checksum byte (XOR of addr, dest, len and payload) and
//    the csum_err pulse. Without it csum_err is tied to 0.
//
// Ports:
//    clk, rst              clock, synchronous active-high reset
//    rx_data/valid/ready   ingress byte stream
//    data_bus              N_CH byte lanes, each a copy of rx_data
//    valid_bus, ready_bus  per-channel handshake, valid one-hot on dest
//    pkt_done, pkt_drop    1-cycle status pulses on the final byte
//    timeout, csum_err     1-cycle abort / checksum error pulses
//    my_state/dest/len/cnt debug views of the parser registers

module pkt_router #(
   parameter int         N_CH        = 5,
   parameter logic [7:0] PREFIX      = 8'hDD,
   parameter logic [7:0] MY_ADDR     = 8'h01,
   parameter int         TIMEOUT_CYC = 20000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [N_CH*8-1:0] data_bus,
   output logic [N_CH-1:0]   valid_bus,
   input  logic [N_CH-1:0]   ready_bus,
   output logic              pkt_done,
   output logic              pkt_drop,
   output logic              timeout,
   output logic              csum_err,
   output logic [2:0]        my_state,
   output logic [7:0]        my_dest,
   output logic [7:0]        my_len,
   output logic [7:0]        my_cnt
);

   localparam int            TW       = $clog2(TIMEOUT_CYC);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [7:0]    N_CH_B   = 8'(N_CH);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_DEST = 3'd2,
      S_LEN  = 3'd3,
      S_DATA = 3'd4,
      S_DROP = 3'd5,
      S_CSUM = 3'd6
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    dest_q, dest_d;
   logic [7:0]    len_q, len_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          addr_ok_q, addr_ok_d;
   logic [TW-1:0] tmo_q, tmo_d;

   logic          accept;
   logic          routed;
   logic          ch_ready;
   logic [7:0]    cnt_inc;
   logic          done_c, drop_c, tmo_c;
`ifdef PKT_ROUTER_CHECKSUM_EN
   logic [7:0]    csum_q, csum_d;
   logic          cerr_c;
`endif

   // Channel select by comparison rather than indexing, so an out-of-range
   // dest simply selects nothing.
   always_comb begin
      ch_ready  = 1'b0;
      valid_bus = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (dest_q == 8'(k)) begin
            ch_ready     = ready_bus[k];
            valid_bus[k] = rx_valid && (state_q == S_DATA);
         end
      end
   end

   assign rx_ready = (state_q == S_DATA) ? ch_ready : 1'b1;
   assign data_bus = {N_CH{rx_data}};
   assign accept   = rx_valid && rx_ready;
   assign routed   = addr_ok_q && (dest_q < N_CH_B);
   assign cnt_inc  = cnt_q + 8'd1;

   always_comb begin
      state_d   = state_q;
      dest_d    = dest_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      addr_ok_d = addr_ok_q;
      tmo_d     = tmo_q;
      done_c    = 1'b0;
      drop_c    = 1'b0;
      tmo_c     = 1'b0;
`ifdef PKT_ROUTER_CHECKSUM_EN
      csum_d    = csum_q;
      cerr_c    = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            if (accept && (rx_data == PREFIX)) state_d = S_ADDR;
         end
         S_ADDR: begin
            if (accept) begin
               addr_ok_d = (rx_data == MY_ADDR);
               state_d   = S_DEST;
`ifdef PKT_ROUTER_CHECKSUM_EN
               csum_d    = rx_data;
`endif
            end
         end
         S_DEST: begin
            if (accept) begin
               dest_d  = rx_data;
               state_d = S_LEN;
`ifdef PKT_ROUTER_CHECKSUM_EN
               csum_d  = csum_q ^ rx_data;
`endif
            end
         end
         S_LEN: begin
            if (accept) begin
               len_d = rx_data;
               cnt_d = '0;
`ifdef PKT_ROUTER_CHECKSUM_EN
               csum_d = csum_q ^ rx_data;
`endif
               if (rx_data == 8'd0) begin
`ifdef PKT_ROUTER_CHECKSUM_EN
                  state_d = S_CSUM;
`else
                  done_c  = routed;
                  drop_c  = !routed;
                  state_d = S_IDLE;
`endif
               end else begin
                  state_d = routed ? S_DATA : S_DROP;
               end
            end
         end
         S_DATA, S_DROP: begin
            if (accept) begin
               cnt_d = cnt_inc;
`ifdef PKT_ROUTER_CHECKSUM_EN
               csum_d = csum_q ^ rx_data;
`endif
               if (cnt_inc == len_q) begin
`ifdef PKT_ROUTER_CHECKSUM_EN
                  state_d = S_CSUM;
`else
                  done_c  = (state_q == S_DATA);
                  drop_c  = (state_q == S_DROP);
                  state_d = S_IDLE;
`endif
               end
            end
         end
`ifdef PKT_ROUTER_CHECKSUM_EN
         S_CSUM: begin
            if (accept) begin
               state_d = S_IDLE;
               if (!routed)                 drop_c = 1'b1;
               else if (rx_data == csum_q)  done_c = 1'b1;
               else                         cerr_c = 1'b1;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // Inter-byte watchdog. An accepted byte always wins over expiry, and a
      // downstream stall (valid high, ready low) freezes the count.
      if (state_q == S_IDLE) begin
         tmo_d = '0;
      end else if (accept) begin
         tmo_d = '0;
      end else if (rx_valid && !rx_ready) begin
         tmo_d = tmo_q;
      end else if (tmo_q == TMO_LAST) begin
         tmo_d   = '0;
         tmo_c   = 1'b1;
         state_d = S_IDLE;
      end else begin
         tmo_d = tmo_q + TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         dest_q    <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         addr_ok_q <= 1'b0;
         tmo_q     <= '0;
      end else begin
         state_q   <= state_d;
         dest_q    <= dest_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         addr_ok_q <= addr_ok_d;
         tmo_q     <= tmo_d;
      end
   end

`ifdef PKT_ROUTER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (rst) csum_q <= '0;
      else     csum_q <= csum_d;
   end
   assign csum_err = cerr_c && !rst;
`else
   assign csum_err = 1'b0;
`endif

   // Pulses are suppressed while reset is held so a packet cut short by
   // reset never reports completion.
   assign pkt_done = done_c && !rst;
   assign pkt_drop = drop_c && !rst;
   assign timeout  = tmo_c && !rst;

   assign my_state = state_q;
   assign my_dest  = dest_q;
   assign my_len   = len_q;
   assign my_cnt   = cnt_q;

endmodule

// File: tb/tb_pkt_router.sv
// tb/tb_pkt_router.sv - self-checking bench for pkt_router
module tb_pkt_router;

   localparam int         N_CH = 5;
   localparam int         TMO  = 40;
   localparam logic [7:0] PFX  = 8'hDD;
   localparam logic [7:0] MY   = 8'h01;

   localparam logic [2:0] EV_DONE = 3'b100;
   localparam logic [2:0] EV_DROP = 3'b010;
   localparam logic [2:0] EV_CERR = 3'b001;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic [N_CH*8-1:0] data_bus;
   logic [N_CH-1:0]   valid_bus;
   logic [N_CH-1:0]   ready_bus;
   logic              pkt_done, pkt_drop, timeout, csum_err;
   logic [2:0]        my_state;
   logic [7:0]        my_dest, my_len, my_cnt;

   always #5 clk = ~clk;

   pkt_router #(.N_CH(N_CH), .PREFIX(PFX), .MY_ADDR(MY), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .data_bus(data_bus), .valid_bus(valid_bus), .ready_bus(ready_bus),
      .pkt_done(pkt_done), .pkt_drop(pkt_drop), .timeout(timeout), .csum_err(csum_err),
      .my_state(my_state), .my_dest(my_dest), .my_len(my_len), .my_cnt(my_cnt)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [N_CH-1:0]   s_vbus;
   logic [N_CH*8-1:0] s_data;
   logic [3:0]        s_pulse;

   typedef struct {
      logic [7:0]      addr;
      logic [7:0]      dest;
      logic [7:0]      len;
      logic [7:0]      first;
      logic [N_CH-1:0] exp_v;
      logic [2:0]      exp_evt;
      int              stall_at;
      int              stall_len;
   } vec_t;

   vec_t tbl[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic snap();
      s_vbus  = valid_bus;
      s_data  = data_bus;
      s_pulse = {pkt_done, pkt_drop, csum_err, timeout};
   endtask

   // Present one byte; returns with the accepting cycle sampled into s_*.
   task automatic put_byte(input logic [7:0] b, input int gap, input int stall,
                           input logic [N_CH-1:0] smask, input logic exp_srdy);
      logic taken;
      taken = 1'b0;
      for (int i = 0; i < gap; i++) begin
         @(negedge clk); rx_valid = 1'b0; ready_bus = '1; #1;
         check("gap_timeout", 32'(timeout), 32'd0);
      end
      for (int i = 0; i < stall && !taken; i++) begin
         @(negedge clk); rx_valid = 1'b1; rx_data = b; ready_bus = ~smask; #1;
         check("stall_rx_ready", 32'(rx_ready), 32'(exp_srdy));
         if (rx_ready) begin
            snap();
            taken = 1'b1;
         end else begin
            check("stall_timeout", 32'(timeout), 32'd0);
         end
      end
      if (!taken) begin
         @(negedge clk); rx_valid = 1'b1; rx_data = b; ready_bus = '1; #1;
         for (int w = 0; w < 8 && !rx_ready; w++) begin
            @(negedge clk); #1;
         end
         if (!rx_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_wait: rx_ready 0, required 1");
         end
         snap();
      end
   endtask

   function automatic logic [N_CH-1:0] model_valid(input logic [7:0] a, input logic [7:0] d);
      if (a == MY && int'(d) < N_CH) return N_CH'(1) << d;
      return '0;
   endfunction

   function automatic logic [2:0] model_evt(input logic [7:0] a, input logic [7:0] d, input bit corrupt);
      if (!(a == MY && int'(d) < N_CH)) return EV_DROP;
      return corrupt ? EV_CERR : EV_DONE;
   endfunction

   task automatic send_pkt(input logic [7:0] addr, input logic [7:0] dest, input logic [7:0] len,
                           input logic [7:0] first, input logic [N_CH-1:0] exp_v,
                           input logic [2:0] exp_evt, input bit rnd,
                           input int stall_at, input int stall_len, input bit corrupt);
      logic [7:0]      bytes[$];
      logic [7:0]      x;
      int              gap, st, lane, last;
      logic [N_CH-1:0] sm;
      logic            srdy;
      bit              is_pay;
      bytes.delete();
      bytes.push_back(PFX);
      bytes.push_back(addr);
      bytes.push_back(dest);
      bytes.push_back(len);
      for (int j = 0; j < int'(len); j++)
         bytes.push_back(rnd ? 8'($urandom) : 8'(int'(first) + j));
      x = addr ^ dest ^ len;
      for (int j = 0; j < int'(len); j++) x = x ^ bytes[4 + j];
      if (corrupt) x = x ^ 8'h01;
`ifdef PKT_ROUTER_CHECKSUM_EN
      bytes.push_back(x);
`endif
      lane = int'(dest);
      last = bytes.size() - 1;
      for (int j = 0; j <= last; j++) begin
         is_pay = (j >= 4) && (j < 4 + int'(len));
         gap = rnd ? int'($urandom_range(0, 3)) : 0;
         st  = 0;
         sm  = '0;
         if (is_pay && rnd) begin
            st = int'($urandom_range(0, 3));
            sm = N_CH'($urandom);
         end
         if (is_pay && (j - 4) == stall_at) begin
            st = stall_len;
            sm = exp_v;
         end
         srdy = ((sm & exp_v) == '0);
         put_byte(bytes[j], gap, st, sm, srdy);
         if (is_pay) begin
            check("valid_bus", 32'(s_vbus), 32'(exp_v));
            if (exp_v != '0) check("lane_data", 32'(s_data[lane*8 +: 8]), 32'(bytes[j]));
         end else if (j == 1) begin
            check("hdr_valid_bus", 32'(s_vbus), 32'd0);
         end
         check("pulses", 32'(s_pulse), (j == last) ? 32'({exp_evt, 1'b0}) : 32'd0);
      end
      @(negedge clk); rx_valid = 1'b0; ready_bus = '1; #1;
      check("end_state", 32'(my_state), 32'd0);
      check("end_cnt", 32'(my_cnt), 32'(len));
      check("end_len", 32'(my_len), 32'(len));
      check("end_dest", 32'(my_dest), 32'(dest));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          hit;
      logic [7:0]  a, d, l;
      bit          c;

      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; ready_bus = '1;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0; #1;
      check("rst_state", 32'(my_state), 32'd0);
      check("rst_rx_ready", 32'(rx_ready), 32'd1);
      check("rst_valid_bus", 32'(valid_bus), 32'd0);
      check("rst_pulses", 32'({pkt_done, pkt_drop, timeout, csum_err}), 32'd0);
      check("rst_dbg", 32'({my_dest, my_len, my_cnt}), 32'd0);

      tbl[0] = '{8'h01, 8'h02, 8'd6,   8'h01, 5'b00100, EV_DONE, -1, 0};
      tbl[1] = '{8'h01, 8'h02, 8'd6,   8'h01, 5'b00100, EV_DONE,  2, 50};
      tbl[2] = '{8'h07, 8'h02, 8'd3,   8'hAA, 5'b00000, EV_DROP, -1, 0};
      tbl[3] = '{8'h01, 8'h00, 8'd1,   8'h55, 5'b00001, EV_DONE, -1, 0};
      tbl[4] = '{8'h01, 8'h09, 8'd2,   8'h11, 5'b00000, EV_DROP, -1, 0};
      tbl[5] = '{8'h01, 8'h04, 8'd0,   8'h00, 5'b00000, EV_DONE, -1, 0};
      tbl[6] = '{8'h07, 8'h00, 8'd0,   8'h00, 5'b00000, EV_DROP, -1, 0};
      tbl[7] = '{8'h01, 8'h05, 8'd1,   8'h33, 5'b00000, EV_DROP, -1, 0};
      tbl[8] = '{8'h01, 8'h03, 8'd4,   8'hDC, 5'b01000, EV_DONE, -1, 0};
      tbl[9] = '{8'h01, 8'h04, 8'd255, 8'h00, 5'b10000, EV_DONE, -1, 0};

      for (int i = 0; i < 10; i++)
         send_pkt(tbl[i].addr, tbl[i].dest, tbl[i].len, tbl[i].first, tbl[i].exp_v,
                  tbl[i].exp_evt, 1'b0, tbl[i].stall_at, tbl[i].stall_len, 1'b0);

      // Header then silence: abort after TMO-1 clock edges past the LEN byte.
      put_byte(PFX, 0, 0, '0, 1'b1);
      put_byte(MY, 0, 0, '0, 1'b1);
      put_byte(8'h01, 0, 0, '0, 1'b1);
      put_byte(8'h04, 0, 0, '0, 1'b1);
      hit = -1;
      for (int k = 1; k <= TMO + 5 && hit < 0; k++) begin
         @(negedge clk); rx_valid = 1'b0; #1;
         if (timeout) begin
            hit = k - 1;
            check("tmo_no_done_drop", 32'({pkt_done, pkt_drop}), 32'd0);
         end
      end
      check("timeout_latency", 32'(hit), 32'(TMO - 1));
      @(negedge clk); #1;
      check("tmo_state", 32'(my_state), 32'd0);
      check("tmo_single_pulse", 32'(timeout), 32'd0);
      send_pkt(8'h01, 8'h00, 8'd1, 8'h55, 5'b00001, EV_DONE, 1'b0, -1, 0, 1'b0);

      // Reset arriving with what would be the final payload byte.
      put_byte(PFX, 0, 0, '0, 1'b1);
      put_byte(MY, 0, 0, '0, 1'b1);
      put_byte(8'h02, 0, 0, '0, 1'b1);
      put_byte(8'h03, 0, 0, '0, 1'b1);
      put_byte(8'h11, 0, 0, '0, 1'b1);
      put_byte(8'h22, 0, 0, '0, 1'b1);
      @(negedge clk); rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h33; #1;
      check("midrst_pulses", 32'({pkt_done, pkt_drop, timeout, csum_err}), 32'd0);
      @(negedge clk); rst = 1'b0; rx_valid = 1'b0; #1;
      check("midrst_state", 32'(my_state), 32'd0);
      check("midrst_dbg", 32'({my_dest, my_len, my_cnt}), 32'd0);
      check("midrst_rx_ready", 32'(rx_ready), 32'd1);

      for (int i = 0; i < 40; i++) begin
         a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : MY;
         d = 8'($urandom_range(0, 7));
         l = 8'($urandom_range(0, 12));
         c = 1'b0;
`ifdef PKT_ROUTER_CHECKSUM_EN
         c = ($urandom_range(0, 3) == 0);
`endif
         send_pkt(a, d, l, 8'h00, model_valid(a, d), model_evt(a, d, c), 1'b1, -1, 0, c);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
